// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-stage controller between the EXE/MEM and MEM/WB
// pipeline registers. Runs one multi-cycle data-memory access per memory
// instruction over a req/ready handshake. It freezes the upstream pipeline
// while the access is outstanding and registers the MEM/WB stage outputs.
module mem_access_unit #(
  parameter int DATA_W  = 32,
  parameter int REG_W   = 5,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  // EXE/MEM register outputs
  input  logic              writeback_enabled,
  input  logic              memory_read_enabled,
  input  logic              memory_write_enabled,
  input  logic [DATA_W-1:0] alu_unit_result,
  input  logic [DATA_W-1:0] STVal,
  input  logic [REG_W-1:0]  destination_source,
  input  logic [DATA_W-1:0] programrun_counter,
  // data-memory port
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  // pipeline freeze
  output logic              stall,
  // MEM/WB register
  output logic              wb_en_out,
  output logic              mem_read_out,
  output logic [DATA_W-1:0] alu_result_out,
  output logic [DATA_W-1:0] mem_data_out,
  output logic [DATA_W-1:0] pc_out,
  output logic [REG_W-1:0]  dest_out,
  // sticky error flags
  output logic              misalign_err,
  output logic              bus_err
);

  // The timeout counter only has to reach TIMEOUT-1. Keep at least one bit
  // so that TIMEOUT=1 still elaborates.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;

  logic is_mem;
  logic access_done;
  logic access_timeout;
  logic misaligned;

  // Force the access onto the containing word. The low address bits only
  // feed the misalignment check.
  function automatic logic [DATA_W-1:0] word_align(input logic [DATA_W-1:0] addr);
    return {addr[DATA_W-1:2], 2'b00};
  endfunction

  assign is_mem         = memory_read_enabled | memory_write_enabled;
  assign misaligned     = (alu_unit_result[1:0] != 2'b00);
  assign access_done    = (state == BUSY) & mem_ready;
  assign access_timeout = (state == BUSY) & ~mem_ready & (cnt == CNT_LAST);

  // Freeze upstream while a memory op waits to start or waits for ready.
  // The final timeout cycle releases the freeze so the squashed op retires.
  always_comb begin
    stall = 1'b0;
    case (state)
      IDLE:    stall = is_mem;
      BUSY:    stall = ~mem_ready & (cnt != CNT_LAST);
      default: stall = 1'b0;
    endcase
  end

  // FSM, timeout counter and memory port registers. Port fields stay
  // stable for the whole BUSY period.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (is_mem) begin
            state     <= BUSY;
            mem_req   <= 1'b1;
            // A simultaneous read+write request is resolved as a write.
            mem_we    <= memory_write_enabled;
            mem_addr  <= word_align(alu_unit_result);
            mem_wdata <= STVal;
          end
        end
        BUSY: begin
          if (access_done || access_timeout) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            cnt     <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
          cnt     <= '0;
        end
      endcase
    end
  end

  // MEM/WB register. It loads on every edge without stall and inserts a
  // bubble otherwise, so a stalled instruction never writes back twice.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_en_out      <= 1'b0;
      mem_read_out   <= 1'b0;
      alu_result_out <= '0;
      mem_data_out   <= '0;
      pc_out         <= '0;
      dest_out       <= '0;
    end else if (stall) begin
      wb_en_out    <= 1'b0;
      mem_read_out <= 1'b0;
    end else begin
      alu_result_out <= alu_unit_result;
      pc_out         <= programrun_counter;
      dest_out       <= destination_source;
      if (access_timeout) begin
        // Bus timeout: squash the instruction.
        wb_en_out    <= 1'b0;
        mem_read_out <= 1'b0;
        mem_data_out <= '0;
      end else if (access_done) begin
        wb_en_out    <= writeback_enabled;
        mem_read_out <= memory_read_enabled & ~mem_we;
        mem_data_out <= mem_we ? '0 : mem_rdata;
      end else begin
        // Non-memory op passing straight through from IDLE.
        wb_en_out    <= writeback_enabled;
        mem_read_out <= 1'b0;
        mem_data_out <= '0;
      end
    end
  end

  // Sticky error flags. Only reset clears them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
    end else begin
      if ((state == IDLE) && is_mem && misaligned) misalign_err <= 1'b1;
      if (access_timeout)                          bus_err      <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  localparam int DATA_W  = 32;
  localparam int REG_W   = 5;
  localparam int TIMEOUT = 4;

  logic              clk;
  logic              reset;
  logic              writeback_enabled, memory_read_enabled, memory_write_enabled;
  logic [DATA_W-1:0] alu_unit_result, STVal, programrun_counter;
  logic [REG_W-1:0]  destination_source;
  logic              mem_req, mem_we, mem_ready;
  logic [DATA_W-1:0] mem_addr, mem_wdata, mem_rdata;
  logic              stall;
  logic              wb_en_out, mem_read_out;
  logic [DATA_W-1:0] alu_result_out, mem_data_out, pc_out;
  logic [REG_W-1:0]  dest_out;
  logic              misalign_err, bus_err;

  int n_checks = 0;
  int n_fail   = 0;

  mem_access_unit #(.DATA_W(DATA_W), .REG_W(REG_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .writeback_enabled(writeback_enabled),
    .memory_read_enabled(memory_read_enabled),
    .memory_write_enabled(memory_write_enabled),
    .alu_unit_result(alu_unit_result), .STVal(STVal),
    .destination_source(destination_source),
    .programrun_counter(programrun_counter),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .stall(stall),
    .wb_en_out(wb_en_out), .mem_read_out(mem_read_out),
    .alu_result_out(alu_result_out), .mem_data_out(mem_data_out),
    .pc_out(pc_out), .dest_out(dest_out),
    .misalign_err(misalign_err), .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic              wb;
    logic [DATA_W-1:0] alu;
    logic [REG_W-1:0]  dest;
    logic [DATA_W-1:0] pc;
    logic              exp_wb;
    logic [DATA_W-1:0] exp_alu;
    logic [REG_W-1:0]  exp_dest;
    logic [DATA_W-1:0] exp_pc;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wb, input logic rd, input logic wr,
                       input logic [DATA_W-1:0] alu, input logic [DATA_W-1:0] st,
                       input logic [REG_W-1:0] dest, input logic [DATA_W-1:0] pc);
    writeback_enabled    = wb;
    memory_read_enabled  = rd;
    memory_write_enabled = wr;
    alu_unit_result      = alu;
    STVal                = st;
    destination_source   = dest;
    programrun_counter   = pc;
  endtask

  initial begin
    vecs[0] = '{1'b1, 32'h0000_0010, 5'd3,  32'h0000_0100, 1'b1, 32'h0000_0010, 5'd3,  32'h0000_0100};
    vecs[1] = '{1'b0, 32'hFFFF_FFFF, 5'd31, 32'h0000_0104, 1'b0, 32'hFFFF_FFFF, 5'd31, 32'h0000_0104};
    vecs[2] = '{1'b1, 32'h8000_0003, 5'd0,  32'hFFFF_FFFC, 1'b1, 32'h8000_0003, 5'd0,  32'hFFFF_FFFC};
    vecs[3] = '{1'b1, 32'h1234_5678, 5'd17, 32'h0000_0000, 1'b1, 32'h1234_5678, 5'd17, 32'h0000_0000};

    reset     = 1'b1;
    mem_ready = 1'b0;
    mem_rdata = '0;
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
    #12;
    // Reset state
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_wb_en", wb_en_out, 0);
    chk("rst_stall", stall, 0);
    chk("rst_flags", {misalign_err, bus_err}, 0);
    reset = 1'b0;
    tick();

    // Load, ready in first BUSY cycle
    drive(1'b1, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 5'd7, 32'h0000_0040);
    mem_rdata = 32'hDEAD_BEEF;
    #1 chk("ld_stall_idle", stall, 1);
    tick();
    chk("ld_mem_req", mem_req, 1);
    chk("ld_mem_we", mem_we, 0);
    chk("ld_mem_addr", mem_addr, 32'h100);
    chk("ld_bubble_wb", wb_en_out, 0);
    mem_ready = 1'b1;
    #1 chk("ld_stall_ready", stall, 0);
    tick();
    chk("ld_mem_req_drop", mem_req, 0);
    chk("ld_wb_en", wb_en_out, 1);
    chk("ld_mem_read", mem_read_out, 1);
    chk("ld_mem_data", mem_data_out, 32'hDEAD_BEEF);
    chk("ld_dest", dest_out, 7);
    chk("ld_pc", pc_out, 32'h40);

    // Non-memory ops from a table; mem_ready stays high to show it is ignored in IDLE
    for (int i = 0; i < 4; i++) begin
      drive(vecs[i].wb, 1'b0, 1'b0, vecs[i].alu, 32'hAAAA_AAAA, vecs[i].dest, vecs[i].pc);
      #1 chk($sformatf("nop%0d_stall", i), stall, 0);
      tick();
      chk($sformatf("nop%0d_wb", i), wb_en_out, vecs[i].exp_wb);
      chk($sformatf("nop%0d_alu", i), alu_result_out, vecs[i].exp_alu);
      chk($sformatf("nop%0d_dest", i), dest_out, vecs[i].exp_dest);
      chk($sformatf("nop%0d_pc", i), pc_out, vecs[i].exp_pc);
      chk($sformatf("nop%0d_mdata", i), mem_data_out, 0);
      chk($sformatf("nop%0d_req", i), mem_req, 0);
    end
    mem_ready = 1'b0;

    // Store with ready in the third BUSY cycle
    drive(1'b0, 1'b0, 1'b1, 32'h0000_0204, 32'h55, 5'd9, 32'h0000_0200);
    #1 chk("st_stall_idle", stall, 1);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("st_req_c%0d", c), mem_req, 1);
      chk($sformatf("st_we_c%0d", c), mem_we, 1);
      chk($sformatf("st_addr_c%0d", c), mem_addr, 32'h204);
      chk($sformatf("st_wdata_c%0d", c), mem_wdata, 32'h55);
      chk($sformatf("st_bubble_c%0d", c), wb_en_out, 0);
      chk($sformatf("st_hold_alu_c%0d", c), alu_result_out, 32'h1234_5678);
      if (c < 2) chk($sformatf("st_stall_c%0d", c), stall, 1);
      else begin
        mem_ready = 1'b1;
        #1 chk("st_stall_ready", stall, 0);
      end
    end
    tick();
    mem_ready = 1'b0;
    chk("st_req_drop", mem_req, 0);
    chk("st_mdata", mem_data_out, 0);
    chk("st_alu", alu_result_out, 32'h204);
    chk("st_mem_read", mem_read_out, 0);
    chk("st_misalign_clear", misalign_err, 0);

    // Misaligned address with read and write both requested
    drive(1'b1, 1'b1, 1'b1, 32'h0000_0103, 32'h77, 5'd4, 32'h0000_0300);
    mem_rdata = 32'h1234_5678;
    tick();
    chk("mis_addr", mem_addr, 32'h100);
    chk("mis_we", mem_we, 1);
    chk("mis_err", misalign_err, 1);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    chk("mis_mem_read", mem_read_out, 0);
    chk("mis_mdata", mem_data_out, 0);
    chk("mis_wb", wb_en_out, 1);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 32'h0);
    tick();
    chk("mis_sticky", misalign_err, 1);

    // Timeout: mem_ready never comes
    drive(1'b1, 1'b1, 1'b0, 32'h0000_0300, 32'h0, 5'd12, 32'h0000_0400);
    for (int c = 0; c < TIMEOUT; c++) begin
      tick();
      chk($sformatf("to_req_c%0d", c), mem_req, 1);
      chk($sformatf("to_stall_c%0d", c), stall, (c == TIMEOUT - 1) ? 1'b0 : 1'b1);
    end
    tick();
    chk("to_req_drop", mem_req, 0);
    chk("to_bus_err", bus_err, 1);
    chk("to_wb_squash", wb_en_out, 0);
    chk("to_rd_squash", mem_read_out, 0);
    drive(1'b1, 1'b0, 1'b0, 32'h0000_0077, 32'h0, 5'd5, 32'h0000_0404);
    #1 chk("to_next_stall", stall, 0);
    tick();
    chk("to_next_wb", wb_en_out, 1);
    chk("to_next_alu", alu_result_out, 32'h77);
    chk("to_bus_err_sticky", bus_err, 1);

    // Asynchronous reset in the middle of BUSY
    drive(1'b1, 1'b1, 1'b0, 32'h0000_0400, 32'h0, 5'd6, 32'h0000_0500);
    tick();
    chk("ar_req_busy", mem_req, 1);
    #2 reset = 1'b1;
    #1;
    chk("ar_req", mem_req, 0);
    chk("ar_addr", mem_addr, 0);
    chk("ar_alu_out", alu_result_out, 0);
    chk("ar_pc_out", pc_out, 0);
    chk("ar_dest_out", dest_out, 0);
    chk("ar_flags", {misalign_err, bus_err}, 0);
    chk("ar_stall_idle", stall, 1);
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
    #1 chk("ar_stall_nop", stall, 0);
    reset = 1'b0;
    tick();
    chk("ar_after_req", mem_req, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
